// File: rtl/sq_wave_pkg.sv
// Shared constants and FSM encoding for the square-wave meter.
// Default timeout is two seconds of the system clock.
package sq_wave_pkg;

    localparam int unsigned CLOCK_FREQUENCY        = 100_000_000;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2 * CLOCK_FREQUENCY;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } meter_state_t;

    // Width of a counter that must reach 'cycles'; at least one bit.
    function automatic int unsigned tmo_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sq_wave_meter_if.sv
// Result channel of the meter: period/high measurement with valid/ready, plus status flags.
// The consumer may hold meas_ready low indefinitely; the meter keeps its result stable.
interface sq_wave_meter_if #(
    parameter int CNT_W = 32
);
    logic [CNT_W-1:0] period_cycles;
    logic [CNT_W-1:0] high_cycles;
    logic             meas_valid;
    logic             meas_ready;
    logic             overrun;
    logic             timeout;

    modport master (
        output period_cycles, high_cycles, meas_valid, overrun, timeout,
        input  meas_ready
    );

    modport slave (
        input  period_cycles, high_cycles, meas_valid, overrun, timeout,
        output meas_ready
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Resynchronises an asynchronous level and flags its edges.
// level lags d_async by SYNC_STAGES cycles; rise/fall are combinational off level and its delayed copy.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_async};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/sq_wave_meter.sv
// Measures rising-to-rising period and high time of sq_in; result one cycle after the closing rise.
// A capture arriving while the previous result is unaccepted is dropped and flagged on overrun.
module sq_wave_meter
    import sq_wave_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sq_in,
    input  logic            enable,
    sq_wave_meter_if.master m
);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam int               TMO_W     = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

    logic s_level, s_rise, s_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (sq_in),
        .level   (s_level),
        .rise    (s_rise),
        .fall    (s_fall)
    );

    meter_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic             hi_done;
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;

    logic tmo_hit;
    logic capture;

    assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LIMIT);
    assign capture = enable && (state == MEASURE) && s_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            hi_done   <= 1'b0;
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else if (!enable) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            hi_done   <= 1'b0;
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= ARM;
                    tmo_cnt <= TMO_W'(1);
                end
                ARM, MEASURE: begin
                    // A rise always beats a timeout landing on the same cycle.
                    if (s_rise) begin
                        state     <= MEASURE;
                        cnt       <= CNT_W'(1);
                        hcnt      <= CNT_W'(1);
                        hi_done   <= 1'b0;
                        tmo_cnt   <= TMO_W'(1);
                        timeout_q <= 1'b0;
                    end else if (tmo_hit) begin
                        state     <= ARM;
                        cnt       <= '0;
                        hcnt      <= '0;
                        tmo_cnt   <= TMO_W'(1);
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == MEASURE) begin
                            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                            if (s_fall) hi_done <= 1'b1;
                            if (s_level && !hi_done && hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [CNT_W-1:0] period_q, high_q;
    logic             valid_q, overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (capture) begin
            if (!valid_q || m.meas_ready) begin
                period_q  <= cnt;
                high_q    <= hcnt;
                valid_q   <= 1'b1;
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= 1'b1;
            end
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && m.meas_ready) valid_q <= 1'b0;
        end
    end

    assign m.period_cycles = period_q;
    assign m.high_cycles   = high_q;
    assign m.meas_valid    = valid_q;
    assign m.overrun       = overrun_q;
    assign m.timeout       = timeout_q;

endmodule

// File: tb/tb_sq_wave_meter.sv
// Randomised and directed bench for sq_wave_meter against a timestamp-based reference.
// Two instances share stimulus: a wide one with timeout and an 8-bit one without.
module tb_sq_wave_meter;

    localparam int S  = 2;
    localparam int TM = 1000;

    logic clk = 1'b0, rst_n = 1'b0, sq_in = 1'b0, enable = 1'b0, meas_ready = 1'b0;
    always #5 clk = ~clk;

    sq_wave_meter_if #(.CNT_W(32)) mif ();
    sq_wave_meter_if #(.CNT_W(8))  sif ();
    assign mif.meas_ready = meas_ready;
    assign sif.meas_ready = meas_ready;

    sq_wave_meter #(.CNT_W(32), .TIMEOUT_CYCLES(TM), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .sq_in(sq_in), .enable(enable), .m(mif)
    );
    sq_wave_meter #(.CNT_W(8), .TIMEOUT_CYCLES(0), .SYNC_STAGES(S)) dut_sat (
        .clk(clk), .rst_n(rst_n), .sq_in(sq_in), .enable(enable), .m(sif)
    );

    // Reference: a measurement is the distance between two rise timestamps and
    // the number of high samples in between; everything else is bookkeeping.
    typedef struct {
        bit     active;
        bit     have;
        longint rref;
        longint hi;
        bit     mv;
        longint per;
        longint hio;
        bit     ovr;
        bit     tmo;
    } mstate_t;

    function automatic mstate_t step(input mstate_t st, input longint cyc, input longint cmax,
                                     input longint tlim, input bit en, input bit rdy,
                                     input bit x, input bit xp);
        mstate_t n;
        bit      rise;
        bit      cap;
        longint  cp, ch;
        n    = st;
        rise = x & ~xp;
        cap  = 1'b0;
        cp   = 0;
        ch   = 0;
        n.ovr = 1'b0;
        if (!en) begin
            n.active = 1'b0; n.have = 1'b0; n.tmo = 1'b0;
        end else if (!st.active) begin
            n.active = 1'b1; n.have = 1'b0; n.rref = cyc;
        end else if (rise) begin
            if (st.have) begin
                cap = 1'b1;
                cp  = (cyc - st.rref > cmax) ? cmax : cyc - st.rref;
                ch  = (st.hi > cmax) ? cmax : st.hi;
            end
            n.have = 1'b1; n.rref = cyc; n.hi = 1; n.tmo = 1'b0;
        end else begin
            if (x) n.hi = st.hi + 1;
            if (tlim != 0 && cyc - st.rref == tlim) begin
                n.tmo = 1'b1; n.have = 1'b0; n.rref = cyc;
            end
        end
        if (cap) begin
            if (!st.mv || rdy) begin n.mv = 1'b1; n.per = cp; n.hio = ch; end
            else n.ovr = 1'b1;
        end else if (st.mv && rdy) begin
            n.mv = 1'b0;
        end
        return n;
    endfunction

    mstate_t    mm, ms;
    logic [S:0] hist;
    longint     cyc = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mm   <= '{default: 0};
            ms   <= '{default: 0};
            hist <= '0;
        end else begin
            mm   <= step(mm, cyc, 64'hFFFF_FFFF, TM, enable, meas_ready, hist[S-1], hist[S]);
            ms   <= step(ms, cyc, 255, 0, enable, meas_ready, hist[S-1], hist[S]);
            hist <= {hist[S-1:0], sq_in};
        end
        cyc <= cyc + 1;
    end

    int     n_checks = 0, n_errors = 0;
    int     ovr_cnt = 0, res_cnt = 0, phase = 0;
    bit     tmo_seen = 0, first_seen = 0, rdy_rand = 0;
    longint first_per = 0, first_hi = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("m_valid",   mif.meas_valid,    mm.mv);
        check("m_period",  mif.period_cycles, mm.per);
        check("m_high",    mif.high_cycles,   mm.hio);
        check("m_overrun", mif.overrun,       mm.ovr);
        check("m_timeout", mif.timeout,       mm.tmo);
        check("s_valid",   sif.meas_valid,    ms.mv);
        check("s_period",  sif.period_cycles, ms.per);
        check("s_high",    sif.high_cycles,   ms.hio);
        check("s_overrun", sif.overrun,       ms.ovr);
        check("s_timeout", sif.timeout,       ms.tmo);
        if (mif.overrun) ovr_cnt++;
        if (mif.meas_valid && meas_ready) res_cnt++;
        if (mif.timeout) tmo_seen = 1'b1;
        if (mif.meas_valid && !first_seen) begin
            first_seen = 1'b1;
            first_per  = mif.period_cycles;
            first_hi   = mif.high_cycles;
        end
    endtask

    task automatic wave(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (phase >= per) phase = 0;
            sq_in = (phase < hi);
            phase = (phase + 1) % per;
            if (rdy_rand) meas_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_valid",  mif.meas_valid, 0);
        check("rst_period", mif.period_cycles, 0);
        check("rst_timeout", mif.timeout, 0);
        rst_n = 1'b1;

        // Nominal 100/50 with an always-ready consumer.
        enable = 1'b1; meas_ready = 1'b1; phase = 0;
        wave(100, 50, 700);
        check("a_first_period", first_per, 100);
        check("a_first_high", first_hi, 50);
        check("a_overrun", ovr_cnt, 0);
        check("a_results", res_cnt, 6);

        // Backpressure: hold ready low for 250 cycles once a result shows.
        for (int i = 0; i < 200 && !mif.meas_valid; i++) wave(100, 50, 1);
        check("b_wait_valid", mif.meas_valid, 1);
        meas_ready = 1'b0; ovr_cnt = 0;
        wave(100, 50, 250);
        check("b_overrun", ovr_cnt, 2);
        check("b_held_period", mif.period_cycles, 100);
        check("b_held_high", mif.high_cycles, 50);
        meas_ready = 1'b1;
        wave(100, 50, 400);

        // Input stuck high long enough to time out, then edges resume.
        tmo_seen = 1'b0; phase = 0;
        wave(1, 1, 1300);
        check("c_timeout_set", mif.timeout, 1);
        check("c_valid_idle", mif.meas_valid, 0);
        phase = 0;
        wave(100, 50, 350);
        check("c_timeout_clr", mif.timeout, 0);

        phase = 0;
        wave(10, 1, 200);
        check("d_period", mif.period_cycles, 10);
        check("d_high", mif.high_cycles, 1);

        phase = 0;
        wave(300, 200, 1500);
        check("e_sat_period", sif.period_cycles, 255);
        check("e_sat_high", sif.high_cycles, 200);
        check("e_wide_period", mif.period_cycles, 300);

        // Random shapes, random consumer, occasional enable drops and stalls.
        rdy_rand = 1'b1;
        for (int seg = 0; seg < 10; seg++) begin
            int per, hi;
            per = $urandom_range(3, 60);
            hi  = $urandom_range(1, per - 1);
            wave(per, hi, $urandom_range(150, 400));
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                wave(per, hi, $urandom_range(1, 30));
                enable = 1'b1;
            end
            if (seg == 5) wave(1, 1, 1200);
        end

        // Enable drop mid-period discards the partial and re-arms.
        rdy_rand = 1'b0; meas_ready = 1'b1; enable = 1'b1; phase = 0;
        wave(100, 50, 250);
        enable = 1'b0; res_cnt = 0;
        wave(100, 50, 40);
        enable = 1'b1;
        wave(100, 50, 105);
        check("g_no_partial", res_cnt, 0);
        wave(100, 50, 20);
        check("g_first_after_rearm", res_cnt, 1);

        // Asynchronous reset with a result pending.
        meas_ready = 1'b0;
        for (int i = 0; i < 400 && !mif.meas_valid; i++) wave(100, 50, 1);
        check("h_wait_valid", mif.meas_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("h_async_valid", mif.meas_valid, 0);
        check("h_async_period", mif.period_cycles, 0);
        check("h_async_high", mif.high_cycles, 0);
        check("h_async_overrun", mif.overrun, 0);
        check("h_async_timeout", mif.timeout, 0);
        check("h_async_sat_valid", sif.meas_valid, 0);
        sq_in = 1'b0;
        tick();
        rst_n = 1'b1; meas_ready = 1'b1; phase = 0; res_cnt = 0;
        wave(100, 50, 100);
        check("h_one_rise_no_result", res_cnt, 0);
        wave(100, 50, 150);
        check("h_results_after", res_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sq_wave_meter.md
Name: sq_wave_meter

Overview:
Measures the square wave produced by the 1 Hz square-wave generator, or any external square wave, and reports period and high time in clk cycles. Sits directly downstream of the generator: the input is resynchronised, edges are detected, and one measurement is captured per rising-to-rising interval. Results are delivered on a valid/ready interface to a status/readout block. Missing edges are flagged with a timeout.

Parameters:
CNT_W, 32, width of the period/high counters and result outputs
TIMEOUT_CYCLES, 200000000, cycles without a rising edge before timeout; 2 s at 100 MHz; 0 disables timeout
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
sq_in  input  1  square wave to measure (asynchronous to clk)
enable  input  1  1 = measure; 0 = idle, counters cleared
period_cycles  output  CNT_W  last captured rising-to-rising interval
high_cycles  output  CNT_W  last captured high time
meas_valid  output  1  result on period_cycles/high_cycles is valid
meas_ready  input  1  consumer accepts result when meas_valid & meas_ready
overrun  output  1  1-cycle pulse: new result dropped because previous not yet accepted
timeout  output  1  level: no rising edge for TIMEOUT_CYCLES cycles

Behaviour:
- Reset (rst_n=0, async): synchroniser flops 0, FSM=IDLE, counters 0, period_cycles=0, high_cycles=0, meas_valid=0, overrun=0, timeout=0.
- Sync: sq_in passes SYNC_STAGES flops -> s. s_d is s delayed 1 cycle. rise = s & ~s_d.
- FSM IDLE: entered whenever enable=0; counters held at 0; timeout=0; pending meas_valid result kept until accepted. enable=1 -> ARM.
- FSM ARM: waits for first rise. tmo_cnt increments each cycle. On rise: cnt<=1, hcnt<=1, timeout<=0, go MEASURE; no result produced.
- FSM MEASURE:
  - cnt increments each cycle, saturating at 2^CNT_W-1.
  - hcnt increments on non-rise cycles where s=1, saturating the same way; it stops when s=0.
  - On rise, capture period=cnt and high=hcnt, then reload cnt<=1, hcnt<=1.
  - Rises N cycles apart give period=N. A high phase of H cycles gives high=H.
- Timeout: when cycles since the last rise (or since entering ARM) reach TIMEOUT_CYCLES, timeout<=1 and FSM -> ARM (partial measurement discarded). timeout stays 1 until the next rise or enable=0.
- Output register:
  - A capture loads period_cycles/high_cycles and sets meas_valid the cycle after the rise, if meas_valid=0 or meas_ready=1 in the capture cycle.
  - Otherwise the capture is dropped, outputs are unchanged, and overrun=1 for exactly that one cycle.
  - Outputs are stable while meas_valid & ~meas_ready.
  - A handshake with no simultaneous capture clears meas_valid next cycle.
- Simultaneous rise and timeout in the same cycle: the rise wins, capture proceeds, timeout is not set.
- enable deasserted mid-measurement: partial discarded immediately; re-enable restarts from ARM.

Decomposition:
- Package sq_wave_pkg: CLOCK_FREQUENCY=100000000, default TIMEOUT_CYCLES derived from it, FSM state enum {IDLE, ARM, MEASURE}.
- One sub-module sync_edge_detect (parameter SYNC_STAGES; ports clk, rst_n, d_async, level, rise, fall), reusable by other input blocks.
- Counters, FSM and output register stay in sq_wave_meter.

Test Plan:
- Measure period 100, high 50: enable=1, TIMEOUT_CYCLES=1000, meas_ready=1, sq_in period 100 / high 50 -> first meas_valid after the 2nd rise with period_cycles=100, high_cycles=50; one result every 100 cycles; overrun never asserted.
- Backpressure: as above with meas_ready=0 for 250 cycles after first valid -> first result (100/50) held stable; overrun pulses exactly twice (1 cycle each); after ready=1 the next capture loads normally.
- Timeout: sq_in held high after a rise, TIMEOUT_CYCLES=1000 -> timeout=1 exactly 1000 cycles after the last rise, no meas_valid; resume edges -> timeout=0 at first rise, first new result after the second rise.
- Minimum duty: period 10, high 1 -> period_cycles=10, high_cycles=1.
- Saturation: CNT_W=8, TIMEOUT_CYCLES=0, period 300, high 200 -> period_cycles=255, high_cycles=200.
- Async reset and enable drop: rst_n low mid-MEASURE with meas_valid=1 -> all outputs 0 immediately without a clock edge; after release, first result only after two rises. Separately, enable=0 mid-period -> no result for the partial period, counters 0.
